// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b computed 4 bits per clock, LSB nibble first.
// Optional NSUB_SATURATE_EN: clamp diff to zero when the operation underflows.
`timescale 1ns/1ps
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  part_q, part_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              c_q, c_d;
    logic              borrow_q, borrow_d;
    logic              done_q, done_d;

    logic [3:0]        nib_a, nib_b;
    logic [4:0]        sum;
    logic              last;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        sum  = {1'b0, nib_a} + {1'b0, ~nib_b} + {4'b0000, c_q};
        last = (idx_q == IDXW'(NIB - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        c_d      = c_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    part_d  = '0;
                    c_d     = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIB; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        part_d[4*i +: 4] = sum[3:0];
                    end
                end
                c_d   = sum[4];
                idx_d = idx_q + IDXW'(1);
                if (last) begin
                    borrow_d = ~sum[4];
`ifdef NSUB_SATURATE_EN
                    diff_d   = sum[4] ? part_d : '0;
`else
                    diff_d   = part_d;
`endif
                    done_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    // The cycle right after acceptance (nibble 0 pending) does not count as busy.
    assign busy   = (state_q == RUN) && (idx_q != '0);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
